counter_seq_ctrl: RTL and testbench

Command-driven sequencer for the team's parameterised up/down counter (enable/preload/mode in, detect/result out). It accepts LOAD / UP-N / DOWN-N commands over a valid/ready handshake and drives the counter's control pins for the exact number of cycles required. It counts the counter's detect (all-ones) pulses during each command and reports completion with a one-cycle done pulse. It sits between a test/host command source and one counter instance.

---
 rtl/counter_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for an up/down counter.
// Accepts LOAD / UP-N / DOWN-N / NOP commands over valid/ready, drives the
// counter control pins for the exact number of cycles, counts the counter's
// detect pulses during each command and signals completion with done.
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             cnt_enable,
    output logic             cnt_preload,
    output logic [WIDTH-1:0] cnt_preload_data,
    output logic             cnt_mode,
    input  logic             cnt_detect,
    input  logic [WIDTH-1:0] cnt_result,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    wrap_cnt,
    output logic [WIDTH-1:0] result_q
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] remaining;
    logic             accept;
    logic             step;
    logic             last_step;
    logic             count_window;
    logic             is_step_op;

    // Handshake and step qualifiers shared by the FSM and datapath
    always_comb begin
        accept       = cmd_valid && (state == S_IDLE);
        is_step_op   = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
        step         = (state == S_RUN) && !abort;
        last_step    = step && (remaining == WIDTH'(1));
        count_window = (state == S_RUN) || (state == S_DRAIN);
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: state_next = S_LOAD;
                        OP_UP,
                        OP_DOWN: state_next = (cmd_data != '0) ? S_RUN : S_DONE;
                        OP_NOP:  state_next = S_DONE;
                        default: state_next = S_DONE;
                    endcase
                end
            end
            S_LOAD:  state_next = S_DONE;
            S_RUN: begin
                // An abort cycle performs no step but still ends the run
                if (abort || last_step) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch and remaining-step countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            data_q    <= '0;
            remaining <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            if (is_step_op) begin
                remaining <= cmd_data;
            end
        end else if (step) begin
            remaining <= remaining - WIDTH'(1);
        end
    end

    // Saturating count of detect pulses seen during RUN and DRAIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_cnt <= '0;
        end else if (accept) begin
            wrap_cnt <= '0;
        end else if (count_window && cnt_detect && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + CW'(1);
        end
    end

    // Capture the counter value on entry to DONE. Leaving LOAD, the counter
    // takes the preload value on this same edge, so the latched data is the
    // value it will hold; all other paths have settled one cycle earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if ((state_next == S_DONE) && (state != S_DONE)) begin
            result_q <= (state == S_LOAD) ? data_q : cnt_result;
        end
    end

    // Control outputs decoded from the current state
    always_comb begin
        cmd_ready        = (state == S_IDLE);
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        cnt_enable       = (state == S_LOAD) || step;
        cnt_preload      = (state == S_LOAD);
        cnt_preload_data = (state == S_LOAD) ? data_q : '0;
        cnt_mode         = (state == S_RUN) && (op_q == OP_DOWN);
    end

    preload_only_in_load: assert property (
        @(posedge clk) disable iff (reset) cnt_preload |-> (state == S_LOAD)
    );

    done_single_cycle: assert property (
        @(posedge clk) disable iff (reset) done |=> !done
    );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: scoreboard bench for counter_seq_ctrl with a
// behavioural up/down counter (registered detect) attached to its pins.
module tb_counter_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CW    = 4;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic             cnt_enable;
    logic             cnt_preload;
    logic [WIDTH-1:0] cnt_preload_data;
    logic             cnt_mode;
    logic             cnt_detect;
    logic [WIDTH-1:0] cnt_result;
    logic             busy;
    logic             done;
    logic [CW-1:0]    wrap_cnt;
    logic [WIDTH-1:0] result_q;

    counter_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .abort            (abort),
        .cnt_enable       (cnt_enable),
        .cnt_preload      (cnt_preload),
        .cnt_preload_data (cnt_preload_data),
        .cnt_mode         (cnt_mode),
        .cnt_detect       (cnt_detect),
        .cnt_result       (cnt_result),
        .busy             (busy),
        .done             (done),
        .wrap_cnt         (wrap_cnt),
        .result_q         (result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter under control: detect is registered from a step that sees all-ones
    logic [WIDTH-1:0] cval;
    logic             cdet;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cval <= '0;
            cdet <= 1'b0;
        end else begin
            cdet <= cnt_enable && !cnt_preload && (cval == '1);
            if (cnt_enable) begin
                if (cnt_preload) cval <= cnt_preload_data;
                else if (cnt_mode) cval <= cval - 1'b1;
                else cval <= cval + 1'b1;
            end
        end
    end
    assign cnt_result = cval;
    assign cnt_detect = cdet;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] res;
        logic [CW-1:0]    wrap;
        int               en;
        int               pl;
        logic             mode;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               en_seen = 0;
    int               pl_seen = 0;
    bit               mode_bad = 0;
    logic [WIDTH-1:0] ref_val = '0;

    // Reference model of one command: expected done cycle, result and detect count
    task automatic predict(input logic [1:0] op, input logic [WIDTH-1:0] d,
                           input int abort_k, input int c, output exp_t e);
        int steps;
        e.cyc  = c + 1;
        e.wrap = '0;
        e.en   = 0;
        e.pl   = 0;
        e.mode = (op == 2'b10);
        if (op == 2'b00) begin
            e.cyc   = c + 2;
            e.en    = 1;
            e.pl    = 1;
            ref_val = d;
        end else if ((op == 2'b01 || op == 2'b10) && d != '0) begin
            steps = (abort_k >= 0 && abort_k < int'(d)) ? abort_k : int'(d);
            for (int i = 0; i < steps; i++) begin
                if (ref_val == '1 && e.wrap != '1) e.wrap = e.wrap + 1'b1;
                ref_val = (op == 2'b01) ? ref_val + 1'b1 : ref_val - 1'b1;
            end
            e.en  = steps;
            e.cyc = (steps < int'(d)) ? c + steps + 3 : c + int'(d) + 2;
        end
        e.res = ref_val;
    endtask

    // Advance one cycle: sample outputs mid-cycle, score any done, then move
    // to just after the next rising edge where stimulus is driven
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            en_seen  = 0;
            pl_seen  = 0;
            mode_bad = 0;
        end else begin
            total++;
            if (cmd_ready !== !busy) begin
                bad++;
                $display("FAIL ready_vs_busy cyc=%0d: ready=%b busy=%b want ready=!busy", cyc, cmd_ready, busy);
            end
            if (cmd_ready === 1'b1) begin
                total++;
                if ({cnt_enable, cnt_preload, cnt_mode} !== 3'b000 || cnt_preload_data !== '0) begin
                    bad++;
                    $display("FAIL idle_outputs cyc=%0d: en=%b pl=%b mode=%b pdata=%h want all 0",
                             cyc, cnt_enable, cnt_preload, cnt_mode, cnt_preload_data);
                end
            end
            total++;
            if (cnt_preload === 1'b1 && cnt_enable !== 1'b1) begin
                bad++;
                $display("FAIL preload_needs_enable cyc=%0d: en=%b pl=%b want en=1", cyc, cnt_enable, cnt_preload);
            end
            en_seen += int'(cnt_enable);
            pl_seen += int'(cnt_preload);
            if (cnt_enable && !cnt_preload && sb.size() != 0 && cnt_mode !== sb[0].mode) mode_bad = 1;
            if (done === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d: done=1 want no done", cyc);
                end else begin
                    e = sb.pop_front();
                    total += 6;
                    if (cyc != e.cyc) begin
                        bad++;
                        $display("FAIL done_cycle: got %0d want %0d", cyc, e.cyc);
                    end
                    if (result_q !== e.res) begin
                        bad++;
                        $display("FAIL result_q cyc=%0d: got %h want %h", cyc, result_q, e.res);
                    end
                    if (wrap_cnt !== e.wrap) begin
                        bad++;
                        $display("FAIL wrap_cnt cyc=%0d: got %0d want %0d", cyc, wrap_cnt, e.wrap);
                    end
                    if (en_seen != e.en) begin
                        bad++;
                        $display("FAIL enable_cycles cyc=%0d: got %0d want %0d", cyc, en_seen, e.en);
                    end
                    if (pl_seen != e.pl) begin
                        bad++;
                        $display("FAIL preload_cycles cyc=%0d: got %0d want %0d", cyc, pl_seen, e.pl);
                    end
                    if (mode_bad || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL mode_busy cyc=%0d: mode_bad=%0d busy=%b want 0/1", cyc, mode_bad, busy);
                    end
                end
                en_seen  = 0;
                pl_seen  = 0;
                mode_bad = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a command, wait (bounded) for acceptance and queue its expectation
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input int abort_k, input bit hold, output int acc);
        exp_t e;
        int   n;
        n         = 0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: ready=%b want 1 within 50 cycles", cmd_ready);
            cmd_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc;
            predict(op, d, abort_k, acc, e);
            sb.push_back(e);
            tick();
            if (!hold) begin
                cmd_valid = 1'b0;
                cmd_op    = ~op;
                cmd_data  = ~d;
            end
            if (abort_k >= 0) begin
                for (int j = 1; j < abort_k + 1; j++) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
        end
    endtask

    // Run until every queued completion has been scored (bounded)
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_data  = '0;
        abort     = 1'b0;
        #1;
        total += 3;
        if ({cmd_ready, busy, done, cnt_enable, cnt_preload, cnt_mode} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {cmd_ready, busy, done, cnt_enable, cnt_preload, cnt_mode});
        end
        if (cnt_preload_data !== '0 || wrap_cnt !== '0) begin
            bad++;
            $display("FAIL reset_data: pdata=%h wrap=%0d want 0/0", cnt_preload_data, wrap_cnt);
        end
        if (result_q !== '0) begin
            bad++;
            $display("FAIL reset_result: got %h want 0", result_q);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int acc;
        issue(2'b00, 4'hA, -1, 1'b0, acc);
        drain();
        total++;
        if (result_q !== 4'hA) begin
            bad++;
            $display("FAIL load_result: got %h want a", result_q);
        end
    endtask

    task automatic test_up();
        int acc;
        issue(2'b00, 4'hC, -1, 1'b0, acc);
        drain();
        issue(2'b01, 4'd6, -1, 1'b0, acc);
        drain();
        tick();
        tick();
        total += 2;
        if (wrap_cnt !== 4'd1) begin
            bad++;
            $display("FAIL up_wrap_held: got %0d want 1", wrap_cnt);
        end
        if (result_q !== 4'h2) begin
            bad++;
            $display("FAIL up_result: got %h want 2", result_q);
        end
    endtask

    task automatic test_down();
        int acc;
        issue(2'b00, 4'h1, -1, 1'b0, acc);
        drain();
        issue(2'b10, 4'd3, -1, 1'b0, acc);
        drain();
        total++;
        if (result_q !== 4'hE || wrap_cnt !== 4'd1) begin
            bad++;
            $display("FAIL down_result: got %h/%0d want e/1", result_q, wrap_cnt);
        end
    endtask

    task automatic test_no_wrap_and_zero();
        int acc;
        issue(2'b00, 4'h0, -1, 1'b0, acc);
        drain();
        issue(2'b01, 4'd15, -1, 1'b0, acc);
        drain();
        issue(2'b01, 4'd0, -1, 1'b0, acc);
        drain();
        issue(2'b11, 4'h7, -1, 1'b0, acc);
        drain();
        total++;
        if (result_q !== 4'hF || wrap_cnt !== '0) begin
            bad++;
            $display("FAIL nowrap_result: got %h/%0d want f/0", result_q, wrap_cnt);
        end
    endtask

    task automatic test_abort();
        int acc;
        abort = 1'b1;
        issue(2'b00, 4'h3, -1, 1'b0, acc);
        drain();
        abort = 1'b0;
        issue(2'b00, 4'h0, -1, 1'b0, acc);
        drain();
        issue(2'b01, 4'd10, 2, 1'b0, acc);
        drain();
        total++;
        if (result_q !== 4'h2) begin
            bad++;
            $display("FAIL abort_result: got %h want 2", result_q);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        issue(2'b00, 4'hE, -1, 1'b0, acc);
        drain();
        issue(2'b01, 4'd10, -1, 1'b0, acc);
        tick();
        tick();
        tick();
        total++;
        if (wrap_cnt !== 4'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL run_wrap_count: wrap=%0d busy=%b want 1/1", wrap_cnt, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        ref_val = '0;
        total += 2;
        if ({cmd_ready, busy, done, cnt_enable, cnt_preload, cnt_mode} !== 6'b100000) begin
            bad++;
            $display("FAIL midreset_ctrl: got %b want 100000",
                     {cmd_ready, busy, done, cnt_enable, cnt_preload, cnt_mode});
        end
        if (wrap_cnt !== '0 || result_q !== '0 || cnt_preload_data !== '0) begin
            bad++;
            $display("FAIL midreset_data: wrap=%0d res=%h pdata=%h want 0/0/0", wrap_cnt, result_q, cnt_preload_data);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        issue(2'b00, 4'h5, -1, 1'b1, acc1);
        issue(2'b01, 4'd2, -1, 1'b0, acc2);
        drain();
        total += 2;
        if (acc2 != acc1 + 3) begin
            bad++;
            $display("FAIL b2b_accept_cycle: got %0d want %0d", acc2, acc1 + 3);
        end
        if (result_q !== 4'h7) begin
            bad++;
            $display("FAIL b2b_result: got %h want 7", result_q);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up();
        test_down();
        test_no_wrap_and_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
